// File: rtl/c432_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : c432_interrupt_controller
// Brief    : Registered 27-channel priority interrupt controller (ISCAS-85
//            c432 function). Bus A beats B beats C; lowest channel wins.
//            Optional macro C432_INPUT_REG_EN adds an input register stage.
// Revision : 1.0 - initial release
// ============================================================================
module c432_interrupt_controller (
    input  logic clk,
    input  logic rst,
    input  logic in1,  input  logic in2,  input  logic in3,
    input  logic in4,  input  logic in5,  input  logic in6,
    input  logic in7,  input  logic in8,  input  logic in9,
    input  logic in10, input  logic in11, input  logic in12,
    input  logic in13, input  logic in14, input  logic in15,
    input  logic in16, input  logic in17, input  logic in18,
    input  logic in19, input  logic in20, input  logic in21,
    input  logic in22, input  logic in23, input  logic in24,
    input  logic in25, input  logic in26, input  logic in27,
    input  logic in28, input  logic in29, input  logic in30,
    input  logic in31, input  logic in32, input  logic in33,
    input  logic in34, input  logic in35, input  logic in36,
    output logic out1,
    output logic out2,
    output logic out3,
    output logic out4,
    output logic out5,
    output logic out6,
    output logic out7
);

    logic [8:0] w_e_in, w_a_in, w_b_in, w_c_in;
    logic [8:0] w_e, w_a, w_b, w_c;

    assign w_e_in = {in9,  in8,  in7,  in6,  in5,  in4,  in3,  in2,  in1};
    assign w_a_in = {in18, in17, in16, in15, in14, in13, in12, in11, in10};
    assign w_b_in = {in27, in26, in25, in24, in23, in22, in21, in20, in19};
    assign w_c_in = {in36, in35, in34, in33, in32, in31, in30, in29, in28};

`ifdef C432_INPUT_REG_EN
    logic [8:0] r_e, r_a, r_b, r_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e <= '0;
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
        end else begin
            r_e <= w_e_in;
            r_a <= w_a_in;
            r_b <= w_b_in;
            r_c <= w_c_in;
        end
    end

    assign w_e = r_e;
    assign w_a = r_a;
    assign w_b = r_b;
    assign w_c = r_c;
`else
    assign w_e = w_e_in;
    assign w_a = w_a_in;
    assign w_b = w_b_in;
    assign w_c = w_c_in;
`endif

    logic [8:0] w_a_eff, w_b_eff, w_c_eff, w_sel;
    logic       w_pa, w_pb, w_pc;
    logic [3:0] w_chan;

    assign w_a_eff = w_a & w_e;
    assign w_b_eff = w_b & w_e;
    assign w_c_eff = w_c & w_e;

    // With no request at all w_sel is zero, so the channel falls back to 0.
    always_comb begin
        w_pa   = |w_a_eff;
        w_pb   = ~w_pa & (|w_b_eff);
        w_pc   = ~w_pa & ~w_pb & (|w_c_eff);
        w_sel  = w_pa ? w_a_eff : (w_pb ? w_b_eff : w_c_eff);
        w_chan = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (w_sel[i]) begin
                w_chan = 4'(i);
            end
        end
    end

    logic       r_pa, r_pb, r_pc;
    logic [3:0] r_chan;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pa   <= 1'b0;
            r_pb   <= 1'b0;
            r_pc   <= 1'b0;
            r_chan <= 4'd0;
        end else begin
            r_pa   <= w_pa;
            r_pb   <= w_pb;
            r_pc   <= w_pc;
            r_chan <= w_chan;
        end
    end

    assign out1 = r_pa;
    assign out2 = r_pb;
    assign out3 = r_pc;
    assign out4 = r_chan[3];
    assign out5 = r_chan[2];
    assign out6 = r_chan[1];
    assign out7 = r_chan[0];

endmodule
`default_nettype wire

// File: tb/tb_c432_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_c432_interrupt_controller
// Brief    : Self-checking bench: directed cases plus random traffic against a
//            priority-rule reference model, including async reset mid-stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c432_interrupt_controller;

`ifdef C432_INPUT_REG_EN
    localparam int C_LAT = 2;
`else
    localparam int C_LAT = 1;
`endif

    logic        clk;
    logic        rst;
    logic [35:0] r_vin;
    logic        out1, out2, out3, out4, out5, out6, out7;

    int          n_assert;
    int          n_fail;
    logic [35:0] r_s_now;
    logic [35:0] r_s_prev;

    c432_interrupt_controller dut (
        .clk (clk), .rst (rst),
        .in1 (r_vin[0]),  .in2 (r_vin[1]),  .in3 (r_vin[2]),
        .in4 (r_vin[3]),  .in5 (r_vin[4]),  .in6 (r_vin[5]),
        .in7 (r_vin[6]),  .in8 (r_vin[7]),  .in9 (r_vin[8]),
        .in10(r_vin[9]),  .in11(r_vin[10]), .in12(r_vin[11]),
        .in13(r_vin[12]), .in14(r_vin[13]), .in15(r_vin[14]),
        .in16(r_vin[15]), .in17(r_vin[16]), .in18(r_vin[17]),
        .in19(r_vin[18]), .in20(r_vin[19]), .in21(r_vin[20]),
        .in22(r_vin[21]), .in23(r_vin[22]), .in24(r_vin[23]),
        .in25(r_vin[24]), .in26(r_vin[25]), .in27(r_vin[26]),
        .in28(r_vin[27]), .in29(r_vin[28]), .in30(r_vin[29]),
        .in31(r_vin[30]), .in32(r_vin[31]), .in33(r_vin[32]),
        .in34(r_vin[33]), .in35(r_vin[34]), .in36(r_vin[35]),
        .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .out5(out5), .out6(out6), .out7(out7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [35:0] mk(input logic [8:0] e, input logic [8:0] a,
                                       input logic [8:0] b, input logic [8:0] c);
        return {c, b, a, e};
    endfunction

    // Result {PA, PB, PC, Chan[3:0]} from the bus/channel priority rules.
    function automatic logic [6:0] model(input logic [35:0] v);
        logic [8:0] en;
        logic [8:0] req [3];
        en     = v[8:0];
        req[0] = v[17:9];
        req[1] = v[26:18];
        req[2] = v[35:27];
        for (int bus = 0; bus < 3; bus++) begin
            for (int ch = 0; ch < 9; ch++) begin
                if (req[bus][ch] && en[ch]) begin
                    return {bus == 0, bus == 1, bus == 2, 4'(ch)};
                end
            end
        end
        return 7'd0;
    endfunction

    function automatic logic [6:0] expected();
        return (C_LAT == 1) ? model(r_s_now) : model(r_s_prev);
    endfunction

    task automatic check_val(input string tag, input logic [6:0] exp_v);
        logic [6:0] act;
        act = {out1, out2, out3, out4, out5, out6, out7};
        n_assert++;
        assert (act === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, act, exp_v);
        end
    endtask

    task automatic clear_model();
        r_s_now  = '0;
        r_s_prev = '0;
    endtask

    // Drive mid-cycle, take one edge, then compare 1 ns after it.
    task automatic step(input logic [35:0] v, input string tag);
        r_vin = v;
        @(posedge clk);
        r_s_prev = r_s_now;
        r_s_now  = r_vin;
        #1;
        check_val(tag, expected());
    endtask

    initial begin
        logic [8:0] e, a, b, c;
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        r_vin    = '0;
        clear_model();

        repeat (2) @(posedge clk);
        #1;
        check_val("reset_hold", 7'd0);
        rst = 1'b0;

        step(36'd0, "all_zero");
        step(36'd0, "all_zero_2");
        step(mk(9'h1FF, 9'h000, 9'h000, 9'h000), "en_only");
        step(mk(9'h1FF, 9'h001, 9'h000, 9'h000), "a0");
        step(mk(9'h1FF, 9'h001, 9'h002, 9'h000), "a0_b1");
        step(mk(9'h1FF, 9'h000, 9'h002, 9'h000), "b1");
        step(mk(9'h1FF, 9'h000, 9'h002, 9'h000), "b1_hold");
        step(mk(9'h1FF, 9'h000, 9'h000, 9'h100), "c8");
        step(mk(9'h1FF, 9'h000, 9'h000, 9'h100), "c8_hold");
        step(mk(9'h0FF, 9'h000, 9'h000, 9'h100), "c8_masked");
        step(mk(9'h0FF, 9'h000, 9'h000, 9'h100), "c8_masked_2");
        step(mk(9'h1FF, 9'h000, 9'h008, 9'h100), "b3_c8");
        step(mk(9'h1FF, 9'h000, 9'h008, 9'h100), "b3_c8_hold");
        step(mk(9'h0FE, 9'h001, 9'h000, 9'h080), "masked_a0_c7");
        step(mk(9'h1FF, 9'h100, 9'h0FF, 9'h0FF), "a8_beats_b");
        step(mk(9'h1FF, 9'h100, 9'h0FF, 9'h0FF), "a8_hold");

        // Mid-cycle reset pulse must clear outputs without a clock edge.
        step(mk(9'h1FF, 9'h020, 9'h000, 9'h000), "pre_rst");
        step(mk(9'h1FF, 9'h020, 9'h000, 9'h000), "pre_rst_2");
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        check_val("async_rst", 7'd0);
        @(posedge clk);
        #1;
        check_val("rst_held", 7'd0);
        rst = 1'b0;
        step(mk(9'h1FF, 9'h020, 9'h000, 9'h000), "post_rst_1");
        step(mk(9'h1FF, 9'h020, 9'h000, 9'h000), "post_rst_2");

        // Sparse random requests so every bus gets to win regularly.
        for (int k = 0; k < 300; k++) begin
            e = 9'($urandom) | 9'($urandom);
            a = 9'($urandom) & 9'($urandom) & 9'($urandom);
            b = 9'($urandom) & 9'($urandom);
            c = 9'($urandom);
            if ($urandom_range(0, 3) == 0) a = '0;
            if ($urandom_range(0, 5) == 0) b = '0;
            step(mk(e, a, b, c), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
